alu_serial_ctrl: RTL
====================

Name: alu_serial_ctrl

Overview:
- Bit-serial sequencer wrapped around one 1-bit ALU slice (ALU1bit); drives the slice's operand, carry and control inputs and consumes its Result/CarryOut.
- Performs one WIDTH-bit ALU operation over WIDTH cycles: one bit per cycle, LSB first.
- Assembles the result word and the zero, carry and overflow flags.
- Area-reduced alternative to the parallel ALU, selected by the CPU datapath for multi-cycle execution.

Parameters:
- WIDTH, 24, operand/result width; bit counter width is $clog2(WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- alu_ctl  in  5  {AInvert, BInvert, Op[2:0]}; captured on accepted start.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse; result and flags valid from this cycle.
- result  out  WIDTH  final result; held until the next accepted start.
- zero  out  1  result == 0.
- carry_out  out  1  final CarryOut for ADD/SUB; 0 otherwise.
- overflow  out  1  signed overflow for ADD/SUB; 0 otherwise.
- illegal  out  1  Op in {101, 110, 111}; valid with done.
- s_a, s_b, s_cin, s_ainv, s_binv, s_less  out  1  slice inputs.
- s_op  out  3  slice Op.
- s_result, s_cout  in  1  slice outputs, combinational in the same cycle.

Behaviour:
- Reset (asynchronous): state IDLE; busy, done, illegal, carry_out, overflow = 0; result = 0; zero = 1; all slice drive outputs = 0.
- Op encoding: 000 AND, 001 OR, 010 ADD, 011 SLT, 100 XOR. SUB = ADD with BInvert=1. NOR = AND with AInvert=BInvert=1.
- IDLE:
  - start=1 captures a, b and alu_ctl into shift registers; clears idx; sets carry_reg = BInvert; goes to RUN.
  - busy rises on the next cycle.
- RUN, processing bit idx (0..WIDTH-1):
  - s_a = a_sh[0], s_b = b_sh[0], s_cin = carry_reg, s_ainv/s_binv from the captured ctl, s_less = 0.
  - s_op = captured Op, except SLT drives 010 (the controller performs the subtract itself).
  - Each clock: shift s_result into result_sh from the MSB side; carry_reg <= s_cout; shift the operands; idx++.
  - At idx == WIDTH-1, also record cin_msb = carry_reg, sum_msb = s_result, cout_msb = s_cout, then go to DONE.
- DONE (exactly one cycle, done=1, busy=0):
  - ADD/SUB: result = result_sh; carry_out = cout_msb; overflow = cin_msb ^ cout_msb.
  - SLT: result = {WIDTH-1 zeros, sum_msb ^ (cin_msb ^ cout_msb)}; carry_out = overflow = 0.
  - Logic ops: result = result_sh; flags = 0.
  - zero computed from the final result. Next state IDLE.
- Latency: start accepted at edge N, done high in the cycle after edge N+WIDTH, i.e. WIDTH+1 cycles from accept. Throughput: one op per WIDTH+2 cycles. start may be asserted during the DONE cycle and is accepted on the following IDLE cycle.
- Illegal Op:
  - Still runs the full WIDTH cycles with s_op forced to 000.
  - Done cycle: result = 0, zero = 1, illegal = 1, all other flags 0.
  - illegal clears on the next accepted start.
- start while busy or in DONE: ignored; operands not re-captured.
- Operand inputs a, b, alu_ctl may change freely after the accept cycle.
- Reset mid-operation: immediate return to the reset values; no done pulse; the partial result is discarded.
- Slice outputs are only ever sampled in RUN; slice inputs are 0 in IDLE and DONE.

Decomposition:
- Shared package alu_pkg:
  - ALU_WIDTH = 24.
  - Op localparams OP_AND, OP_OR, OP_ADD, OP_SLT, OP_XOR.
  - alu_ctl field positions.
  - State enum {IDLE, RUN, DONE}.
- Natural sub-module: alu_serial_shreg, a WIDTH-bit load/shift register instantiated three times (a, b, result). The 1-bit slice is instantiated by the parent, not inside this block.

Test Plan:
- ADD: a=0x000005, b=0x000003, ctl=00010 -> done 25 cycles after accept; result 0x000008, zero 0, carry_out 0, overflow 0.
- SUB: a=0x000003, b=0x000003, ctl=01010 -> result 0x000000, zero 1, carry_out 1, overflow 0. ADD a=0x7FFFFF, b=0x000001 -> result 0x800000, overflow 1.
- SLT, ctl=01011: a=0xFFFFFF, b=0x000001 -> result 0x000001. Overflow case a=0x7FFFFF, b=0x800000 -> result 0x000000.
- Logic ops:
  - NOR ctl=11000, a=0x0F0F0F, b=0x00FF00 -> 0xF000F0.
  - XOR ctl=00100, a=0xFFFF00, b=0x0F0F0F -> 0xF0F00F.
  - OR ctl=00001, a=0x800000, b=0x000001 -> 0x800001.
- Control and boundary:
  - Pulse start again at bit 5 -> ignored; result unchanged.
  - Assert reset at bit 10 -> busy 0, done never pulses, result 0, zero 1.
  - Back-to-back op accepted the cycle after done.
- Illegal: ctl=00101 -> done after 25 cycles; illegal 1, result 0, zero 1; next legal op clears illegal.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, control-field positions and state type for the serial ALU
package alu_pkg;

    localparam int ALU_WIDTH = 24;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    // alu_ctl = {AInvert, BInvert, Op[2:0]}
    localparam int CTL_AINV   = 4;
    localparam int CTL_BINV   = 3;
    localparam int CTL_OP_MSB = 2;
    localparam int CTL_OP_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic op_illegal(input logic [2:0] op);
        return op > OP_XOR;
    endfunction

endpackage

// File: rtl/alu_serial_shreg.sv
// rtl/alu_serial_shreg.sv - load/shift-right register; exposes the low OUT_W bits of its contents
module alu_serial_shreg #(
    parameter int WIDTH = 24,
    parameter int OUT_W = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             sin,
    output logic [OUT_W-1:0] q
);

    logic [WIDTH-1:0] store;

    // new bits enter at the MSB, so the LSB is always the next bit out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            store <= '0;
        end else if (load) begin
            store <= load_data;
        end else if (shift) begin
            store <= {sin, store[WIDTH-1:1]};
        end
    end

    assign q = store[OUT_W-1:0];

endmodule

// File: rtl/alu_serial_ctrl.sv
// rtl/alu_serial_ctrl.sv - bit-serial sequencer driving an external 1-bit ALU slice, LSB first
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       alu_ctl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic             illegal,
    output logic             s_a,
    output logic             s_b,
    output logic             s_cin,
    output logic             s_ainv,
    output logic             s_binv,
    output logic             s_less,
    output logic [2:0]       s_op,
    input  logic             s_result,
    input  logic             s_cout
);

    localparam int              IDXW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [4:0]       ctl_q;
    logic [2:0]       op_q;
    logic [IDXW-1:0]  idx;
    logic             carry_reg;
    logic             slt_q;
    logic             slt_bit_q;
    logic             accept;
    logic             running;
    logic             last_bit;
    logic             a_bit;
    logic             b_bit;
    logic [WIDTH-1:0] res_sh;

    assign op_q     = ctl_q[CTL_OP_MSB:CTL_OP_LSB];
    assign accept   = (state == IDLE) && start;
    assign running  = (state == RUN);
    assign last_bit = running && (idx == LAST_IDX);

    alu_serial_shreg #(.WIDTH(WIDTH), .OUT_W(1)) u_a_sh (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_data (a),
        .shift     (running),
        .sin       (1'b0),
        .q         (a_bit)
    );

    alu_serial_shreg #(.WIDTH(WIDTH), .OUT_W(1)) u_b_sh (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_data (b),
        .shift     (running),
        .sin       (1'b0),
        .q         (b_bit)
    );

    alu_serial_shreg #(.WIDTH(WIDTH), .OUT_W(WIDTH)) u_res_sh (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_data ({WIDTH{1'b0}}),
        .shift     (running),
        .sin       (s_result),
        .q         (res_sh)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        s_a       = 1'b0;
        s_b       = 1'b0;
        s_cin     = 1'b0;
        s_ainv    = 1'b0;
        s_binv    = 1'b0;
        s_less    = 1'b0;
        s_op      = 3'b000;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                s_a    = a_bit;
                s_b    = b_bit;
                s_cin  = carry_reg;
                s_ainv = ctl_q[CTL_AINV];
                s_binv = ctl_q[CTL_BINV];
                // SLT runs as a subtract; the less bit is derived here, not in the slice
                if (op_illegal(op_q)) begin
                    s_op = OP_AND;
                end else if (op_q == OP_SLT) begin
                    s_op = OP_ADD;
                end else begin
                    s_op = op_q;
                end
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_q     <= '0;
            idx       <= '0;
            carry_reg <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            slt_q     <= 1'b0;
            slt_bit_q <= 1'b0;
        end else if (accept) begin
            ctl_q     <= alu_ctl;
            idx       <= '0;
            carry_reg <= alu_ctl[CTL_BINV];
            illegal   <= 1'b0;
            slt_q     <= 1'b0;
        end else if (running) begin
            carry_reg <= s_cout;
            idx       <= idx + 1'b1;
            // MSB cycle: carry into and out of the top bit give overflow and the SLT sign
            if (last_bit) begin
                illegal   <= op_illegal(op_q);
                slt_q     <= (op_q == OP_SLT);
                slt_bit_q <= s_result ^ carry_reg ^ s_cout;
                carry_out <= (op_q == OP_ADD) && s_cout;
                overflow  <= (op_q == OP_ADD) && (carry_reg ^ s_cout);
            end
        end
    end

    always_comb begin
        result = res_sh;
        if (illegal) begin
            result = '0;
        end else if (slt_q) begin
            result = {{(WIDTH-1){1'b0}}, slt_bit_q};
        end
    end

    assign zero = (result == '0);

endmodule
